// File: rtl/vchip_pkg.sv
// vchip_pkg: default parameters and parameter sanity helper for virtual_chip_v2
package vchip_pkg;
  localparam int DEF_ADD_W = 4;
  localparam int DEF_OSC_DIV = 4;
  localparam int DEF_PAT_LEN = 8;
  localparam int DEF_CNT_W = 8;
  localparam logic [15:0] DEF_PATTERN = 16'h00b2;
  function automatic bit pat_len_ok(input int len);
    return len >= 2 && len <= 16;
  endfunction
endpackage

// File: rtl/virtual_chip_v2_if.sv
// virtual_chip_v2_if: pin bundle between the tester pin driver and the virtual chip
interface virtual_chip_v2_if #(
  parameter int N_INV = 2,
  parameter int ADD_W = 4,
  parameter int CNT_W = 8
);
  logic [N_INV-1:0] inv_in;
  logic [N_INV-1:0] inv_out;
  logic osc_en;
  logic osc_out;
  logic [ADD_W-1:0] add_a;
  logic [ADD_W-1:0] add_b;
  logic add_ci;
  logic add_valid;
  logic [ADD_W-1:0] add_sum;
  logic add_co;
  logic add_valid_out;
  logic ser_in;
  logic ser_valid;
  logic ser_clr;
  logic overlap;
  logic match;
  logic [CNT_W-1:0] match_cnt;
  modport master(
    output inv_in, osc_en, add_a, add_b, add_ci, add_valid, ser_in, ser_valid, ser_clr, overlap,
    input inv_out, osc_out, add_sum, add_co, add_valid_out, match, match_cnt
  );
  modport slave(
    input inv_in, osc_en, add_a, add_b, add_ci, add_valid, ser_in, ser_valid, ser_clr, overlap,
    output inv_out, osc_out, add_sum, add_co, add_valid_out, match, match_cnt
  );
endinterface

// File: rtl/seq_recognizer.sv
// seq_recognizer: serial pattern matcher with overlap control, clear and saturating match count
module seq_recognizer
  import vchip_pkg::*;
#(
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter logic [15:0] PATTERN = DEF_PATTERN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ser_in,
  input  logic ser_valid,
  input  logic ser_clr,
  input  logic overlap,
  output logic match,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int FW = $clog2(PAT_LEN + 1);
  logic [PAT_LEN-1:0] hist, hist_nx;
  logic [FW-1:0] fill, fill_nx;
  logic hit;
  // the match is judged on the history as it will look after taking the incoming bit
  always_comb begin
    hist_nx = {hist[PAT_LEN-2:0], ser_in};
    fill_nx = (fill == FW'(PAT_LEN)) ? fill : fill + 1'b1;
    hit = ser_valid && fill_nx == FW'(PAT_LEN) && hist_nx == PATTERN[PAT_LEN-1:0];
  end
  // shift history, track fill, pulse match and count; clear beats an incoming bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
      match <= 1'b0;
      match_cnt <= '0;
    end else if (ser_clr) begin
      hist <= '0;
      fill <= '0;
      match <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= hit;
      if (ser_valid) begin
        hist <= hist_nx;
        fill <= (hit && !overlap) ? '0 : fill_nx;
      end
      if (hit && !(&match_cnt)) match_cnt <= match_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/virtual_chip_v2.sv
// virtual_chip_v2: known-good virtual DUT with inverters, oscillator, registered adder and recogniser
module virtual_chip_v2
  import vchip_pkg::*;
#(
  parameter int N_INV = 2,
  parameter int ADD_W = DEF_ADD_W,
  parameter int OSC_DIV = DEF_OSC_DIV,
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter logic [15:0] PATTERN = DEF_PATTERN,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  virtual_chip_v2_if.slave bus
);
  localparam int OW = (OSC_DIV > 1) ? $clog2(OSC_DIV) : 1;
  logic [OW-1:0] osc_cnt;
  if (!pat_len_ok(PAT_LEN)) begin : g_bad_len
    $error("virtual_chip_v2: PAT_LEN must be 2..16");
  end
  assign bus.inv_out = ~bus.inv_in;
  // divide clk: toggle every OSC_DIV enabled edges, park low when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_cnt <= '0;
      bus.osc_out <= 1'b0;
    end else if (!bus.osc_en) begin
      osc_cnt <= '0;
      bus.osc_out <= 1'b0;
    end else if (osc_cnt == OW'(OSC_DIV - 1)) begin
      osc_cnt <= '0;
      bus.osc_out <= ~bus.osc_out;
    end else begin
      osc_cnt <= osc_cnt + 1'b1;
    end
  end
  // register the sum on each operand strobe; result holds between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.add_sum <= '0;
      bus.add_co <= 1'b0;
      bus.add_valid_out <= 1'b0;
    end else begin
      bus.add_valid_out <= bus.add_valid;
      if (bus.add_valid)
        {bus.add_co, bus.add_sum} <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{ADD_W{1'b0}}, bus.add_ci};
    end
  end
  seq_recognizer #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(CNT_W)) u_rec (
    .clk(clk),
    .rst_n(rst_n),
    .ser_in(bus.ser_in),
    .ser_valid(bus.ser_valid),
    .ser_clr(bus.ser_clr),
    .overlap(bus.overlap),
    .match(bus.match),
    .match_cnt(bus.match_cnt)
  );
endmodule

// File: tb/tb_virtual_chip_v2.sv
// tb_virtual_chip_v2: directed scoreboard bench for a default chip and a short-pattern, 2-bit-count chip
module tb_virtual_chip_v2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [4:0] add_q[$];
  logic ma_q[$];
  logic mb_q[$];
  logic [7:0] pat;
  logic [5:0] s6, e_ov, e_no;
  always #5 clk = ~clk;
  virtual_chip_v2_if #(.N_INV(2), .ADD_W(4), .CNT_W(8)) ia ();
  virtual_chip_v2_if #(.N_INV(2), .ADD_W(4), .CNT_W(2)) ib ();
  virtual_chip_v2 dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  virtual_chip_v2 #(.OSC_DIV(1), .PAT_LEN(4), .PATTERN(16'h000a), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    logic v;
    v = ia.add_valid;
    @(posedge clk);
    #1;
    chk("add_valid_out", 32'(ia.add_valid_out), 32'(v));
    if (v) chk("add_result", 32'({ia.add_co, ia.add_sum}), 32'(add_q.pop_front()));
    if (ma_q.size() > 0) chk("match_a", 32'(ia.match), 32'(ma_q.pop_front()));
    else if (ia.match) chk("match_a_spurious", 32'(ia.match), 32'd0);
    if (mb_q.size() > 0) chk("match_b", 32'(ib.match), 32'(mb_q.pop_front()));
    else if (ib.match) chk("match_b_spurious", 32'(ib.match), 32'd0);
    ia.add_valid = 1'b0;
    ia.ser_valid = 1'b0;
    ia.ser_clr = 1'b0;
    ib.ser_valid = 1'b0;
    ib.ser_clr = 1'b0;
  endtask
  task automatic add(input logic [3:0] a, input logic [3:0] b, input logic ci);
    ia.add_a = a;
    ia.add_b = b;
    ia.add_ci = ci;
    ia.add_valid = 1'b1;
    add_q.push_back({1'b0, a} + {1'b0, b} + {4'b0, ci});
    step();
  endtask
  task automatic feed_a(input logic b, input logic m);
    ia.ser_in = b;
    ia.ser_valid = 1'b1;
    ma_q.push_back(m);
    step();
  endtask
  task automatic feed_b(input logic b, input logic m);
    ib.ser_in = b;
    ib.ser_valid = 1'b1;
    mb_q.push_back(m);
    step();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_osc_a"}, 32'(ia.osc_out), 32'd0);
    chk({tag, "_sum_a"}, 32'({ia.add_co, ia.add_sum}), 32'd0);
    chk({tag, "_vo_a"}, 32'(ia.add_valid_out), 32'd0);
    chk({tag, "_match_a"}, 32'(ia.match), 32'd0);
    chk({tag, "_cnt_a"}, 32'(ia.match_cnt), 32'd0);
    chk({tag, "_osc_b"}, 32'(ib.osc_out), 32'd0);
    chk({tag, "_match_b"}, 32'(ib.match), 32'd0);
    chk({tag, "_cnt_b"}, 32'(ib.match_cnt), 32'd0);
  endtask
  initial begin
    {ia.inv_in, ia.osc_en, ia.add_a, ia.add_b, ia.add_ci, ia.add_valid} = '0;
    {ia.ser_in, ia.ser_valid, ia.ser_clr, ia.overlap} = '0;
    {ib.inv_in, ib.osc_en, ib.add_a, ib.add_b, ib.add_ci, ib.add_valid} = '0;
    {ib.ser_in, ib.ser_valid, ib.ser_clr, ib.overlap} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    ia.inv_in = 2'b01;
    ib.inv_in = 2'b11;
    #1;
    chk("inv_a_01", 32'(ia.inv_out), 32'd2);
    chk("inv_b_11", 32'(ib.inv_out), 32'd0);
    ia.inv_in = 2'b10;
    #1;
    chk("inv_a_10", 32'(ia.inv_out), 32'd1);
    add(4'hf, 4'h1, 1'b1);
    step();
    chk("add_hold", 32'({ia.add_co, ia.add_sum}), 32'h11);
    add(4'h0, 4'h0, 1'b0);
    add(4'hf, 4'hf, 1'b1);
    for (int i = 0; i < 6; i++) add(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    step();
    ia.osc_en = 1'b1;
    ib.osc_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("osc_a", 32'(ia.osc_out), 32'((k / 4) % 2));
      chk("osc_b", 32'(ib.osc_out), 32'(k % 2));
    end
    ia.osc_en = 1'b0;
    ib.osc_en = 1'b0;
    step();
    chk("osc_a_off", 32'(ia.osc_out), 32'd0);
    chk("osc_b_off", 32'(ib.osc_out), 32'd0);
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) feed_a(pat[i], i == 0);
    chk("cnt_a_first", 32'(ia.match_cnt), 32'd1);
    step();
    chk("match_a_drop", 32'(ia.match), 32'd0);
    for (int i = 7; i >= 0; i--) begin
      feed_a(pat[i], i == 0);
      step();
    end
    chk("cnt_a_gapped", 32'(ia.match_cnt), 32'd2);
    s6 = 6'b101010;
    e_ov = 6'b000101;
    e_no = 6'b000100;
    ib.overlap = 1'b1;
    for (int i = 5; i >= 0; i--) feed_b(s6[i], e_ov[i]);
    chk("cnt_b_overlap", 32'(ib.match_cnt), 32'd2);
    ib.ser_clr = 1'b1;
    step();
    chk("cnt_b_clr", 32'(ib.match_cnt), 32'd0);
    ib.overlap = 1'b0;
    for (int i = 5; i >= 0; i--) feed_b(s6[i], e_no[i]);
    chk("cnt_b_no_overlap", 32'(ib.match_cnt), 32'd1);
    ib.ser_clr = 1'b1;
    step();
    ib.overlap = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      feed_b(1'(j % 2), (j % 2 == 0) && (j >= 4));
      if (j == 10) chk("cnt_b_sat4", 32'(ib.match_cnt), 32'd3);
    end
    chk("cnt_b_sat5", 32'(ib.match_cnt), 32'd3);
    feed_b(1'b1, 1'b0);
    ib.ser_clr = 1'b1;
    feed_b(1'b0, 1'b0);
    chk("cnt_b_clr_wins", 32'(ib.match_cnt), 32'd0);
    ia.osc_en = 1'b1;
    ib.osc_en = 1'b1;
    add(4'h3, 4'h4, 1'b0);
    repeat (5) step();
    chk("pre_rst_osc_a", 32'(ia.osc_out), 32'd1);
    ia.ser_in = 1'b1;
    ia.ser_valid = 1'b1;
    ib.ser_in = 1'b1;
    ib.ser_valid = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    ia.add_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/virtual_chip_v2.md
# virtual_chip_v2

Parametrised second-generation virtual DUT for the chip tester. It is instantiated behind the FPGA pin driver/sampler in place of a physical chip. It provides four functions as a known-good reference: an inverter bank, a clock-derived oscillator, a registered ripple adder and a serial pattern recogniser. Compared with the first generation, the adder width, oscillator divide, recogniser pattern and length are all configurable. The recogniser also gains overlap/non-overlap modes, a clear input and a match counter.

## Interface
Parameters:
- N_INV, 2, number of independent inverters
- ADD_W, 4, adder operand width (1..16)
- OSC_DIV, 4, clk cycles per oscillator half-period (>=1)
- PAT_LEN, 8, recogniser pattern length (2..16)
- PATTERN, 8'b1011_0010, PAT_LEN-bit pattern; MSB is the first bit received
- CNT_W, 8, match counter width

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  system clock from FPGA fabric; stands in for the analog oscillator core
- rst_n  in  1  async active-low reset
- inv_in  in  N_INV  inverter inputs
- inv_out  out  N_INV  inverter outputs
- osc_en  in  1  oscillator enable
- osc_out  out  1  oscillator output
- add_a, add_b  in  ADD_W  adder operands
- add_ci  in  1  carry in
- add_valid  in  1  operand strobe
- add_sum  out  ADD_W  registered sum
- add_co  out  1  registered carry out
- add_valid_out  out  1  result-valid strobe
- ser_in  in  1  serial data bit
- ser_valid  in  1  ser_in qualifier
- ser_clr  in  1  synchronous recogniser clear
- overlap  in  1  1 = overlapping matches allowed
- match  out  1  one-cycle match pulse
- match_cnt  out  CNT_W  saturating match count

## Operation
- Reset values: osc_out=0, add_sum=0, add_co=0, add_valid_out=0, match=0, match_cnt=0; all internal counters and shift state cleared. Reset mid-operation aborts everything immediately.
- Inverters: inv_out = ~inv_in, purely combinational. This is the only combinational path.
- Oscillator:
  - Counter runs 0..OSC_DIV-1 while osc_en=1.
  - On an enabled edge with counter==OSC_DIV-1: osc_out toggles and the counter wraps to 0.
  - osc_en=0: counter cleared and osc_out forced to 0 on the next edge.
  - OSC_DIV=1 gives clk/2.
- Adder:
  - On an edge with add_valid=1: {add_co,add_sum} <= add_a + add_b + add_ci (ADD_W+1-bit result), and add_valid_out <= 1.
  - Otherwise add_valid_out <= 0 and the result holds.
- Recogniser:
  - On an edge with ser_valid=1: hist <= {hist[PAT_LEN-2:0], ser_in}; fill count increments, saturating at PAT_LEN.
  - Match condition: fill==PAT_LEN after the update and the updated hist == PATTERN. The condition is evaluated on the incoming bit.
  - On a match: match=1 for exactly one cycle; match_cnt increments, saturating at all-ones.
  - overlap=0: a match resets fill to 0, so a new match needs PAT_LEN fresh bits.
  - overlap=1: fill is kept after a match.
  - ser_valid=0: no shift and no match; match deasserts.
  - ser_clr=1: clears hist, fill, match and match_cnt on that edge. It wins over a simultaneous ser_valid; that bit is discarded.
  - overlap is sampled on each match edge and may change between bits.

## Timing
- inv_out: 0 cycles (combinational).
- Adder: 1-cycle latency. Back-to-back add_valid gives one result per cycle.
- Recogniser: match is asserted in the cycle after the edge that samples the completing bit.
- Oscillator: first rise on the OSC_DIV-th enabled edge; period is 2*OSC_DIV clk; duty cycle 50%.
- No backpressure; all strobes are single-cycle qualifiers.

## Structure
- Package `vchip_pkg`: default parameter constants (DEF_PATTERN, DEF_PAT_LEN, DEF_ADD_W, DEF_OSC_DIV, DEF_CNT_W) and a function checking that PAT_LEN <= 16.
- Sub-module `seq_recognizer`: history shift register, fill counter, overlap logic, match pulse and saturating counter.
- Oscillator, adder and inverters stay inline in `virtual_chip_v2`.

## Test plan
- Reset: assert rst_n=0 mid-stream with osc_en=1 and ser_valid=1 -> all outputs 0 asynchronously and hold 0 until release.
- Oscillator, OSC_DIV=4: osc_en=1 at edge 0 -> osc_out rises at edge 4, falls at edge 8. osc_en=0 -> osc_out=0 on the next edge.
- Adder, ADD_W=4: add_a=4'hF, add_b=4'h1, add_ci=1 with add_valid -> next cycle add_sum=4'h1, add_co=1, add_valid_out=1 for one cycle.
- Recogniser default, overlap=0: feed bits 1,0,1,1,0,0,1,0 -> match=1 one cycle after the 8th bit; match_cnt=1. With ser_valid gaps between bits, the result is the same.
- Overlap modes, PAT_LEN=4, PATTERN=4'b1010, stream 1,0,1,0,1,0:
  - overlap=1 -> matches after bits 4 and 6; match_cnt=2.
  - overlap=0 -> match after bit 4 only; match_cnt=1.
- Clear and saturation, CNT_W=2:
  - Four matches -> match_cnt=3, held.
  - ser_clr together with ser_valid on a completing bit -> no match; match_cnt=0.
